// File: rtl/reg_file_sb_if.sv
// Bus bundle for the scoreboarded register file: two read ports, one write port,
// one claim port, plus busy/stall/double-claim status back to the requester.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              claim;
    logic [ADDR_W-1:0] ca;
    logic              rs_busy;
    logic              rt_busy;
    logic              stall;
    logic              dbl_claim;

    modport master (
        output rs, rt, we, wa, wd, claim, ca,
        input  rd1, rd2, rs_busy, rt_busy, stall, dbl_claim
    );

    modport slave (
        input  rs, rt, we, wa, wd, claim, ca,
        output rd1, rd2, rs_busy, rt_busy, stall, dbl_claim
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a per-register busy (pending-write) scoreboard and double-claim detection.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regsQ [NREGS];
    logic [DATA_W-1:0] regsD [NREGS];
    logic [NREGS-1:0]  busyQ;
    logic [NREGS-1:0]  busyD;
    logic              dblClaimQ;
    logic              dblClaimD;

    logic              writeHit;
    logic              claimHit;

    assign writeHit = bus.we && (bus.wa != '0);
    assign claimHit = bus.claim && (bus.ca != '0);

    // A claim landing on the edge that also retires the same register is the newer
    // producer taking over, so busy stays set and it is not a double claim.
    always_comb begin
        regsD     = regsQ;
        busyD     = busyQ;
        dblClaimD = 1'b0;
        if (writeHit) begin
            regsD[bus.wa] = bus.wd;
        end
        if (bus.we) begin
            busyD[bus.wa] = 1'b0;
        end
        if (claimHit) begin
            busyD[bus.ca] = 1'b1;
            dblClaimD     = busyQ[bus.ca] && !(bus.we && (bus.wa == bus.ca));
        end
        busyD[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regsQ[i] <= '0;
            end
            busyQ     <= '0;
            dblClaimQ <= 1'b0;
        end else begin
            regsQ     <= regsD;
            busyQ     <= busyD;
            dblClaimQ <= dblClaimD;
        end
    end

    logic [DATA_W-1:0] storedRs;
    logic [DATA_W-1:0] storedRt;

    assign storedRs = (bus.rs == '0) ? '0 : regsQ[bus.rs];
    assign storedRt = (bus.rt == '0) ? '0 : regsQ[bus.rt];

`ifdef REGFILE_BYPASS_EN
    logic fwdRs;
    logic fwdRt;

    assign fwdRs = writeHit && (bus.wa == bus.rs);
    assign fwdRt = writeHit && (bus.wa == bus.rt);

    // The in-flight write satisfies the reader this cycle, so it must not stall on it.
    always_comb begin
        bus.rd1     = fwdRs ? bus.wd : storedRs;
        bus.rd2     = fwdRt ? bus.wd : storedRt;
        bus.rs_busy = fwdRs ? 1'b0 : busyQ[bus.rs];
        bus.rt_busy = fwdRt ? 1'b0 : busyQ[bus.rt];
    end
`else
    always_comb begin
        bus.rd1     = storedRs;
        bus.rd2     = storedRt;
        bus.rs_busy = busyQ[bus.rs];
        bus.rt_busy = busyQ[bus.rt];
    end
`endif

    assign bus.stall     = bus.rs_busy | bus.rt_busy;
    assign bus.dbl_claim = dblClaimQ;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed steps drive the bus, a reference
// model and directed constants feed a scoreboard queue that is drained each cycle.
module tb_reg_file_sb;
    logic clk;
    logic rst;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] expVal;
        string       tag;
    } expEntry_t;

    expEntry_t   scoreQ[$];
    int          checks;
    int          errors;

    logic [31:0] mRegs [16];
    logic [15:0] mBusy;
    logic        mDbl;

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mRegs[i] = '0;
        mBusy = '0;
        mDbl  = 1'b0;
    endtask

    task automatic pushEntry(input int kind, input logic [31:0] v, input string tag);
        expEntry_t e;
        e.kind   = kind;
        e.expVal = v;
        e.tag    = tag;
        scoreQ.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge and queue the model's view of outputs.
    task automatic applyStimulus(input logic [3:0] rsV, input logic [3:0] rtV,
                                 input logic weV, input logic [3:0] waV, input logic [31:0] wdV,
                                 input logic claimV, input logic [3:0] caV, input logic rstV);
        logic [31:0] e1, e2;
        logic        b1, b2;
        @(negedge clk);
        bus.rs = rsV; bus.rt = rtV; bus.we = weV; bus.wa = waV; bus.wd = wdV;
        bus.claim = claimV; bus.ca = caV; rst = rstV;
        e1 = (rsV == 4'd0) ? 32'd0 : mRegs[rsV];
        e2 = (rtV == 4'd0) ? 32'd0 : mRegs[rtV];
        b1 = mBusy[rsV];
        b2 = mBusy[rtV];
`ifdef REGFILE_BYPASS_EN
        if (weV && waV != 4'd0 && waV == rsV) begin e1 = wdV; b1 = 1'b0; end
        if (weV && waV != 4'd0 && waV == rtV) begin e2 = wdV; b2 = 1'b0; end
`endif
        pushEntry(0, e1, "model_rd1");
        pushEntry(1, e2, "model_rd2");
        pushEntry(2, {31'd0, b1}, "model_rs_busy");
        pushEntry(3, {31'd0, b2}, "model_rt_busy");
        pushEntry(4, {31'd0, b1 | b2}, "model_stall");
        pushEntry(5, {31'd0, mDbl}, "model_dbl_claim");
    endtask

    // Compare everything queued for this cycle, then advance one edge and the model.
    task automatic checkOutput();
        expEntry_t   e;
        logic [31:0] obs;
        #1;
        while (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            case (e.kind)
                0:       obs = bus.rd1;
                1:       obs = bus.rd2;
                2:       obs = {31'd0, bus.rs_busy};
                3:       obs = {31'd0, bus.rt_busy};
                4:       obs = {31'd0, bus.stall};
                default: obs = {31'd0, bus.dbl_claim};
            endcase
            checks++;
            assert (obs === e.expVal) else begin
                errors++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.expVal);
            end
        end
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            mDbl = bus.claim && bus.ca != 4'd0 && mBusy[bus.ca] && !(bus.we && bus.wa == bus.ca);
            if (bus.we && bus.wa != 4'd0) mRegs[bus.wa] = bus.wd;
            if (bus.we) mBusy[bus.wa] = 1'b0;
            if (bus.claim && bus.ca != 4'd0) mBusy[bus.ca] = 1'b1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.rs = '0; bus.rt = '0; bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.claim = 1'b0; bus.ca = '0;
        modelReset();
        repeat (2) @(posedge clk);

        // Reset state
        applyStimulus(4'd0, 4'd1, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'd0, "reset_rd1");
        pushEntry(4, 32'd0, "reset_stall");
        pushEntry(5, 32'd0, "reset_dbl");
        checkOutput();

        // Random writes and claims, then a reset edge that also carries we/claim
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1,
                          4'($urandom_range(1, 15)), $urandom, 1,
                          4'($urandom_range(1, 15)), 0);
            checkOutput();
        end
        applyStimulus(4'd1, 4'd2, 1, 4'd7, 32'h55, 1, 4'd7, 1);
        checkOutput();
        for (int a = 1; a < 16; a += 2) begin
            applyStimulus(4'(a), 4'(a + 1), 0, 4'd0, 32'd0, 0, 4'd0, 0);
            pushEntry(0, 32'd0, "postrst_rd1");
            pushEntry(1, 32'd0, "postrst_rd2");
            pushEntry(4, 32'd0, "postrst_stall");
            pushEntry(5, 32'd0, "postrst_dbl");
            checkOutput();
        end

        // Plain write and read-back
        applyStimulus(4'd0, 4'd0, 1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 0);
        checkOutput();
        applyStimulus(4'd5, 4'd5, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'hDEADBEEF, "wr5_rd1");
        pushEntry(1, 32'hDEADBEEF, "wr5_rd2");
        checkOutput();

        // Register 0 ignores writes and claims
        applyStimulus(4'd0, 4'd0, 1, 4'd0, 32'h1234, 1, 4'd0, 0);
        checkOutput();
        applyStimulus(4'd0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'd0, "r0_rd1");
        pushEntry(2, 32'd0, "r0_busy");
        checkOutput();

        // Claim, stall, then retire by a write
        applyStimulus(4'd0, 4'd0, 0, 4'd0, 32'd0, 1, 4'd3, 0);
        checkOutput();
        applyStimulus(4'd3, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(2, 32'd1, "claim3_rs_busy");
        pushEntry(4, 32'd1, "claim3_stall");
        checkOutput();
        applyStimulus(4'd3, 4'd0, 1, 4'd3, 32'd7, 0, 4'd0, 0);
        checkOutput();
        applyStimulus(4'd3, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'd7, "retire3_rd1");
        pushEntry(2, 32'd0, "retire3_rs_busy");
        pushEntry(4, 32'd0, "retire3_stall");
        checkOutput();

        // Double claim pulses for exactly one cycle
        applyStimulus(4'd0, 4'd0, 0, 4'd0, 32'd0, 1, 4'd3, 0);
        pushEntry(5, 32'd0, "dbl_first");
        checkOutput();
        applyStimulus(4'd0, 4'd0, 0, 4'd0, 32'd0, 1, 4'd3, 0);
        pushEntry(5, 32'd0, "dbl_second_edge");
        checkOutput();
        applyStimulus(4'd3, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(5, 32'd1, "dbl_pulse");
        pushEntry(2, 32'd1, "dbl_still_busy");
        checkOutput();
        applyStimulus(4'd0, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(5, 32'd0, "dbl_end");
        checkOutput();

        // Same-edge claim and write: claim wins, and with busy already set no double claim
        applyStimulus(4'd0, 4'd0, 1, 4'd6, 32'd9, 1, 4'd6, 0);
        checkOutput();
        applyStimulus(4'd6, 4'd6, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'd9, "same6_rd1");
        pushEntry(2, 32'd1, "same6_rs_busy");
        pushEntry(3, 32'd1, "same6_rt_busy");
        checkOutput();
        applyStimulus(4'd0, 4'd0, 1, 4'd6, 32'd10, 1, 4'd6, 0);
        checkOutput();
        applyStimulus(4'd6, 4'd0, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(5, 32'd0, "same6_no_dbl");
        pushEntry(0, 32'd10, "same6_rd1_again");
        checkOutput();

        // Write to a non-busy register
        applyStimulus(4'd0, 4'd0, 1, 4'd8, 32'hA5A5_0F0F, 0, 4'd0, 0);
        checkOutput();
        applyStimulus(4'd8, 4'd5, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'hA5A5_0F0F, "nb8_rd1");
        pushEntry(2, 32'd0, "nb8_busy");
        checkOutput();

        // Same-cycle write observed on both read ports
        applyStimulus(4'd0, 4'd0, 1, 4'd4, 32'd22, 1, 4'd4, 0);
        checkOutput();
        applyStimulus(4'd4, 4'd4, 1, 4'd4, 32'd11, 0, 4'd0, 0);
`ifdef REGFILE_BYPASS_EN
        pushEntry(0, 32'd11, "byp_rd1");
        pushEntry(1, 32'd11, "byp_rd2");
        pushEntry(4, 32'd0, "byp_stall");
`else
        pushEntry(0, 32'd22, "nobyp_rd1");
        pushEntry(1, 32'd22, "nobyp_rd2");
        pushEntry(4, 32'd1, "nobyp_stall");
`endif
        checkOutput();
        applyStimulus(4'd4, 4'd4, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'd11, "after4_rd1");
        pushEntry(4, 32'd0, "after4_stall");
        checkOutput();

        // Mid-operation reset abandons a pending claim
        applyStimulus(4'd0, 4'd0, 0, 4'd0, 32'd0, 1, 4'd10, 0);
        checkOutput();
        applyStimulus(4'd10, 4'd0, 0, 4'd0, 32'd0, 1, 4'd10, 1);
        checkOutput();
        applyStimulus(4'd10, 4'd0, 1, 4'd10, 32'd5, 0, 4'd0, 0);
        pushEntry(2, 32'd0, "midrst_busy_cleared");
        pushEntry(5, 32'd0, "midrst_dbl");
        checkOutput();
        applyStimulus(4'd10, 4'd6, 0, 4'd0, 32'd0, 0, 4'd0, 0);
        pushEntry(0, 32'd5, "midrst_rd1");
        pushEntry(1, 32'd0, "midrst_r6_cleared");
        pushEntry(2, 32'd0, "midrst_rs_busy");
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; depth NREGS = 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port rs and port rt, both input, ADDR_W wide, the read addresses for ports 1 and 2.
REQ-006 SHALL have port rd1 and port rd2, both output, DATA_W wide, the combinational read data for rs and rt.
REQ-007 SHALL have port we, input, 1, the write enable.
REQ-008 SHALL have port wa, input, ADDR_W wide, the write address.
REQ-009 SHALL have port wd, input, DATA_W wide, the write data.
REQ-010 SHALL have port claim, input, 1, which marks register ca as pending-write (busy).
REQ-011 SHALL have port ca, input, ADDR_W wide, the claim address.
REQ-012 SHALL have port rs_busy and port rt_busy, both output, 1, the pending-write status of rs and rt.
REQ-013 SHALL have port stall, output, 1, equal to rs_busy OR rt_busy.
REQ-014 SHALL have port dbl_claim, output, 1, a registered one-cycle pulse on a claim of an already-busy register.

Function
REQ-015 SHALL hold NREGS registers of DATA_W bits plus one busy bit per register.
REQ-016 SHALL hardwire register 0: rd1/rd2 read 0, writes ignored, claims ignored, busy[0] always 0.
REQ-017 SHALL write wd into R[wa] at the clock edge when we=1 and wa!=0; zero read latency otherwise.
REQ-018 SHALL clear busy[wa] at the clock edge when we=1.
REQ-019 SHALL set busy[ca] at the clock edge when claim=1 and ca!=0.
REQ-020 SHALL, on the same edge with claim=1, we=1 and ca==wa, write the data and leave busy[ca]=1 (claim wins: newer producer).
REQ-021 SHALL accept a write to a non-busy register as a normal write with busy unchanged at 0.
REQ-022 SHALL assert dbl_claim for exactly the cycle after an edge where claim=1, ca!=0 and busy[ca]=1 and not cleared by a same-edge write.
REQ-023 SHALL allow rs==rt; both ports return identical data and busy.
REQ-024 SHALL treat a read of a busy register as returning the current stored value; the consumer uses stall to qualify it.

Reset
REQ-025 SHALL, on an edge with rst=1, clear all registers to 0, all busy bits to 0, and dbl_claim to 0; rst overrides we and claim on that edge.
REQ-026 SHALL, after reset, present rd1=rd2=0, rs_busy=rt_busy=stall=0, dbl_claim=0.
REQ-027 SHALL abandon pending claims on a mid-operation reset; a later write to a formerly busy register behaves as REQ-021.

Configuration
REQ-028 SHALL, with REGFILE_BYPASS_EN defined, forward wd to rd1 (rd2) combinationally when we=1, wa!=0 and wa==rs (rt), and force rs_busy (rt_busy) to 0 for that address in that cycle.
REQ-029 SHALL, without REGFILE_BYPASS_EN, return only stored values and registered busy bits; a same-cycle write is visible from the next cycle.

Verification
REQ-030 SHALL cover: rst=1 for one edge after random writes -> all reads 0, stall=0, dbl_claim=0.
REQ-031 SHALL cover: we=1, wa=5, wd=32'hDEADBEEF, then rs=5 -> rd1=32'hDEADBEEF next cycle; writes and claims to reg 0 -> rd1=0 and busy[0]=0.
REQ-032 SHALL cover: claim ca=3, then rs=3 -> rs_busy=1 and stall=1; we=1 wa=3 wd=7 -> rs_busy=0 and rd1=7 on the next cycle.
REQ-033 SHALL cover: claim ca=3 twice with no write between -> dbl_claim=1 for exactly one cycle after the second edge.
REQ-034 SHALL cover: same edge claim ca=6, we=1 wa=6 wd=9 -> R6=9 and busy[6]=1 afterwards.
REQ-035 SHALL cover: with REGFILE_BYPASS_EN, we=1 wa=4 wd=11 and rs=rt=4 in the same cycle -> rd1=rd2=11 and stall=0 in that cycle; without the macro -> old value in that cycle.
